// File: rtl/irq_timer.sv
// irq_timer: 16-bit prescaled down-counting timer (one-shot or periodic) with
// MMIO register access and a level interrupt equal to EXP & IE.
module irq_timer #(
   parameter int P_PRESC_W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sel,
   input  logic        i_we,
   input  logic        i_re,
   input  logic [2:0]  i_addr,
   input  logic [15:0] i_wdata,
   output logic [15:0] o_rdata,
   output logic        o_rdy,
   output logic        o_irq
);
   logic                 r_en, r_per, r_ie, r_exp, r_ovr;
   logic [15:0]          r_reload, r_count, r_rdata;
   logic [P_PRESC_W-1:0] r_presc, r_pcnt;
   logic                 w_wr, w_rd, w_ctrl_wr, w_stat_wr, w_load, w_tick, w_expire, w_en_nxt, w_hold;
   logic [15:0]          w_rdata;

   assign w_wr      = i_sel & i_we;
   assign w_rd      = i_sel & i_re;
   assign w_ctrl_wr = w_wr & (i_addr == 3'b000);
   assign w_stat_wr = w_wr & (i_addr == 3'b110);
   assign w_load    = w_ctrl_wr & i_wdata[0] & (~r_en | i_wdata[3]);
   assign w_hold    = w_ctrl_wr & ~i_wdata[0];
   assign w_tick    = r_en & (r_pcnt == r_presc);
   assign w_expire  = w_tick & (r_count == 16'd0);
   // a CTRL write overrides the one-shot auto-disable on the same edge
   assign w_en_nxt  = w_ctrl_wr ? i_wdata[0] : r_en & ~(w_expire & ~r_per);
   assign o_rdy     = i_sel;
   assign o_irq     = r_exp & r_ie;
   assign o_rdata   = r_rdata;

   always_comb begin
      w_rdata = 16'h0000;
      case (i_addr)
         3'b000:  w_rdata = {13'd0, r_ie, r_per, r_en};
         3'b001:  w_rdata = r_count;
         3'b010:  w_rdata = r_reload;
         3'b100:  w_rdata = 16'(r_presc);
         3'b110:  w_rdata = {14'd0, r_ovr, r_exp};
         default: w_rdata = 16'h0000;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_en     <= 1'b0;
         r_per    <= 1'b0;
         r_ie     <= 1'b0;
         r_reload <= 16'hFFFF;
         r_presc  <= '0;
         r_count  <= 16'd0;
         r_pcnt   <= '0;
         r_exp    <= 1'b0;
         r_ovr    <= 1'b0;
         r_rdata  <= 16'h0000;
      end else begin
         r_en <= w_en_nxt;
         if (w_ctrl_wr) begin
            r_per <= i_wdata[1];
            r_ie  <= i_wdata[2];
         end
         if (w_wr && i_addr == 3'b010) r_reload <= i_wdata;
         if (w_wr && i_addr == 3'b100) r_presc <= i_wdata[P_PRESC_W-1:0];
         if (w_load) r_count <= r_reload;
         else if (w_tick && !w_hold)
            r_count <= (r_count != 16'd0) ? r_count - 16'd1 : (r_per ? r_reload : r_count);
         r_pcnt  <= (w_load | ~w_en_nxt | w_tick) ? '0 : r_pcnt + 1'b1;
         // a same-edge expiry beats a W1C clear
         r_exp   <= (r_exp & ~(w_stat_wr & i_wdata[0])) | w_expire;
         r_ovr   <= (r_ovr & ~(w_stat_wr & i_wdata[1])) | (w_expire & r_exp);
         r_rdata <= w_rd ? w_rdata : 16'h0000;
      end
   end
endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: table vectors, directed corner sequences and random traffic
// checked every cycle against a behavioural model of the timer.
module tb_irq_timer;
   logic        i_clk = 1'b0, i_rst = 1'b1, i_sel = 1'b0, i_we = 1'b0, i_re = 1'b0;
   logic [2:0]  i_addr = 3'd0;
   logic [15:0] i_wdata = 16'd0;
   logic [15:0] o_rdata;
   logic        o_rdy, o_irq;
   int          checks = 0, failures = 0;

   irq_timer dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy), .o_irq(o_irq)
   );

   always #5 i_clk = ~i_clk;

   logic        m_en, m_per, m_ie, m_exp, m_ovr;
   logic [15:0] m_reload, m_count, m_rdata;
   logic [7:0]  m_presc, m_pcnt;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Timer progress first, then the bus write applied on top of it.
   task automatic model_step(input logic rst, s, w, r, input logic [2:0] a, input logic [15:0] d);
      logic expired;
      logic [15:0] n_count;
      logic [7:0]  n_pcnt;
      logic        n_en, n_exp, n_ovr;
      if (rst) begin
         {m_en, m_per, m_ie, m_exp, m_ovr} = 5'd0;
         m_reload = 16'hFFFF; m_presc = 8'd0; m_count = 16'd0; m_pcnt = 8'd0; m_rdata = 16'd0;
         return;
      end
      m_rdata = 16'd0;
      if (s && r) begin
         case (a)
            3'd0: m_rdata = {13'd0, m_ie, m_per, m_en};
            3'd1: m_rdata = m_count;
            3'd2: m_rdata = m_reload;
            3'd4: m_rdata = {8'd0, m_presc};
            3'd6: m_rdata = {14'd0, m_ovr, m_exp};
            default: m_rdata = 16'd0;
         endcase
      end
      expired = 1'b0; n_count = m_count; n_pcnt = m_pcnt; n_en = m_en; n_exp = m_exp; n_ovr = m_ovr;
      if (m_en) begin
         if (m_pcnt == m_presc) begin
            n_pcnt = 8'd0;
            if (m_count != 0) n_count = m_count - 1;
            else begin
               expired = 1'b1;
               n_exp = 1'b1;
               if (m_exp) n_ovr = 1'b1;
               if (m_per) n_count = m_reload; else n_en = 1'b0;
            end
         end else n_pcnt = m_pcnt + 8'd1;
      end
      if (!n_en) n_pcnt = 8'd0;
      if (s && w) begin
         case (a)
            3'd0: begin
               if (d[0] && (!m_en || d[3])) begin n_count = m_reload; n_pcnt = 8'd0; end
               else if (!d[0]) begin n_count = m_count; n_pcnt = 8'd0; end
               n_en = d[0]; m_per = d[1]; m_ie = d[2];
            end
            3'd2: m_reload = d;
            3'd4: m_presc = d[7:0];
            3'd6: begin
               if (d[0] && !expired) n_exp = 1'b0;
               if (d[1] && !(expired && m_exp)) n_ovr = 1'b0;
            end
            default: ;
         endcase
      end
      m_count = n_count; m_pcnt = n_pcnt; m_en = n_en; m_exp = n_exp; m_ovr = n_ovr;
   endtask

   task automatic step(input logic rst, s, w, r, input logic [2:0] a, input logic [15:0] d);
      i_rst = rst; i_sel = s; i_we = w; i_re = r; i_addr = a; i_wdata = d;
      #1 chk("rdy", {15'd0, o_rdy}, {15'd0, s});
      model_step(rst, s, w, r, a, d);
      @(posedge i_clk);
      #1;
      chk("model_irq", {15'd0, o_irq}, {15'd0, m_exp & m_ie});
      chk("model_rdata", o_rdata, m_rdata);
   endtask

   task automatic idle(); step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0); endtask
   task automatic wr(input logic [2:0] a, input logic [15:0] d); step(1'b0, 1'b1, 1'b1, 1'b0, a, d); endtask
   task automatic rd(input logic [2:0] a); step(1'b0, 1'b1, 1'b0, 1'b1, a, 16'd0); endtask

   typedef struct {
      logic        s, w, r;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] rdata;
      logic        irq;
   } vec_t;

   vec_t        vecs[18];
   logic [2:0]  ra;
   logic [15:0] rd16;
   int unsigned p;

   initial begin
      vecs[0]  = '{1, 0, 1, 3'd0, 16'd0, 16'h0000, 0};
      vecs[1]  = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[2]  = '{1, 0, 1, 3'd2, 16'd0, 16'hFFFF, 0};
      vecs[3]  = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[4]  = '{1, 0, 1, 3'd4, 16'd0, 16'h0000, 0};
      vecs[5]  = '{1, 0, 1, 3'd6, 16'd0, 16'h0000, 0};
      vecs[6]  = '{1, 0, 1, 3'd1, 16'd0, 16'h0000, 0};
      vecs[7]  = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[8]  = '{1, 1, 0, 3'd2, 16'd4, 16'h0000, 0};
      vecs[9]  = '{1, 1, 0, 3'd4, 16'd0, 16'h0000, 0};
      vecs[10] = '{1, 1, 0, 3'd0, 16'd5, 16'h0000, 0};
      vecs[11] = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[12] = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[13] = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[14] = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 0};
      vecs[15] = '{0, 0, 0, 3'd0, 16'd0, 16'h0000, 1};
      vecs[16] = '{1, 0, 1, 3'd0, 16'd0, 16'h0004, 1};
      vecs[17] = '{1, 0, 1, 3'd1, 16'd0, 16'h0000, 1};

      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
      chk("reset_irq", {15'd0, o_irq}, 16'd0);
      for (int i = 0; i < 18; i++) begin
         step(1'b0, vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
         chk($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].rdata);
         chk($sformatf("vec%0d_irq", i), {15'd0, o_irq}, {15'd0, vecs[i].irq});
      end

      wr(3'd6, 16'd1);
      chk("oneshot_clear_irq", {15'd0, o_irq}, 16'd0);
      for (int i = 0; i < 50; i++) idle();
      rd(3'd6);
      chk("oneshot_no_reexpiry", o_rdata, 16'h0000);

      wr(3'd2, 16'd2);
      wr(3'd4, 16'd1);
      wr(3'd0, 16'd7);
      for (int k = 1; k <= 6; k++) begin
         idle();
         chk($sformatf("per_first_k%0d", k), {15'd0, o_irq}, {15'd0, k == 6});
      end
      for (int k = 1; k <= 6; k++) idle();
      rd(3'd6);
      chk("per_status_ovr", o_rdata, 16'h0003);
      wr(3'd6, 16'd3);
      chk("per_w1c_irq_low", {15'd0, o_irq}, 16'd0);

      wr(3'd0, 16'd0);
      wr(3'd6, 16'd3);
      wr(3'd2, 16'd0);
      wr(3'd4, 16'd0);
      wr(3'd0, 16'd7);
      wr(3'd6, 16'd1);
      chk("collide_irq_high", {15'd0, o_irq}, 16'd1);
      rd(3'd6);
      chk("collide_exp_kept", o_rdata, 16'h0001);

      wr(3'd0, 16'd0);
      wr(3'd6, 16'd3);
      wr(3'd2, 16'd10);
      wr(3'd0, 16'd1);
      for (int i = 0; i < 7; i++) idle();
      wr(3'd0, 16'd0);
      for (int i = 0; i < 20; i++) idle();
      rd(3'd1);
      chk("stop_hold_count", o_rdata, 16'd3);
      wr(3'd0, 16'h000D);
      rd(3'd1);
      chk("restart_reload", o_rdata, 16'd10);
      wr(3'd0, 16'h0005);
      rd(3'd1);
      chk("en_again_no_reload", o_rdata, 16'd8);

      for (int k = 0; k < 20 && !o_irq; k++) idle();
      chk("irq_before_reset", {15'd0, o_irq}, 16'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
      chk("reset_mid_irq", {15'd0, o_irq}, 16'd0);
      rd(3'd0);
      chk("post_reset_ctrl", o_rdata, 16'h0000);
      rd(3'd2);
      chk("post_reset_reload", o_rdata, 16'hFFFF);
      rd(3'd1);
      chk("post_reset_count", o_rdata, 16'h0000);

      for (int n = 0; n < 4000; n++) begin
         p = $urandom_range(99);
         ra = 3'($urandom_range(7));
         if ($urandom_range(2) == 0) ra = 3'd0;
         rd16 = 16'($urandom);
         if (ra == 3'd0) rd16 = 16'($urandom_range(15));
         if (ra == 3'd2) rd16 = 16'($urandom_range(6));
         if (ra == 3'd4) rd16 = 16'($urandom_range(2));
         if (p < 1) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
         else if (p < 50) idle();
         else if (p < 72) rd(3'($urandom_range(7)));
         else wr(ra, rd16);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
